// File: rtl/multiplexor_display_pkg.sv
// Shared constants, types and nibble helpers for the four-digit multiplexed display.
// Provides display_pkg, imported by the interface, the prescaler and the top.
package display_pkg;

  localparam int NUM_DIGITOS = 4;
  localparam int IDX_W       = 2;
  localparam logic [NUM_DIGITOS-1:0] ANODO_OFF = 4'b1111;

  typedef logic [IDX_W-1:0]         idx_t;
  typedef logic [4*NUM_DIGITOS-1:0] dato_t;

  function automatic logic [3:0] nibble(input dato_t r, input idx_t i);
    logic [3:0] n;
    case (i)
      2'd0:    n = r[3:0];
      2'd1:    n = r[7:4];
      2'd2:    n = r[11:8];
      default: n = r[15:12];
    endcase
    return n;
  endfunction

  // True when digit i and every digit above it are zero; digit 0 never qualifies.
  function automatic logic lead_zero(input dato_t r, input idx_t i);
    logic z;
    case (i)
      2'd0:    z = 1'b0;
      2'd1:    z = (r[15:4] == 12'h000);
      2'd2:    z = (r[15:8] == 8'h00);
      default: z = (r[15:12] == 4'h0);
    endcase
    return z;
  endfunction

endpackage

// File: rtl/multiplexor_display_if.sv
// Data/display bundle between a host (master) and the multiplexed display (slave).
interface multiplexor_display_if;
  import display_pkg::*;

  logic                   load;
  dato_t                  dato;
  logic [3:0]             numero;
  logic [NUM_DIGITOS-1:0] anodo;
  logic                   blanco;

  modport master (output load, output dato, input numero, input anodo, input blanco);
  modport slave  (input load, input dato, output numero, output anodo, output blanco);

endinterface

// File: rtl/multiplexor_display_divisor_tick.sv
// Prescaler: counts 0..DIV_MAX-1 and raises tick during the cycle that wraps to 0.
module divisor_tick #(
  parameter int DIV_MAX = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_MAX - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/multiplexor_display.sv
// Four-digit multiplexed hex display scanner with a one-cycle load register.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module multiplexor_display
  import display_pkg::*;
#(
  parameter int DIV_MAX = 50000
) (
  input logic                  clk,
  input logic                  reset,
  multiplexor_display_if.slave bus
);

  logic  tick;
  dato_t disp;
  idx_t  idx;

  divisor_tick #(.DIV_MAX(DIV_MAX)) u_divisor (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp <= '0;
      idx  <= '0;
    end else begin
      if (bus.load) disp <= bus.dato;
      if (tick)     idx  <= idx + idx_t'(1);
    end
  end

  // Outputs depend only on registered state, so load/dato never reach them combinationally.
  always_comb begin
    bus.numero = nibble(disp, idx);
    bus.anodo  = ~(NUM_DIGITOS'(1) << idx);
    bus.blanco = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (lead_zero(disp, idx)) begin
      bus.anodo  = ANODO_OFF;
      bus.blanco = 1'b1;
    end
`endif
  end

endmodule
